// File: rtl/sync_fifo_flags_if.sv
// Handshake/status bundle for sync_fifo_flags: the producer/consumer side drives
// the master modport, the FIFO itself sits on the slave modport.
interface sync_fifo_flags_if #(
    parameter int WIDTH = 8,
    parameter int PTR   = 4
);
    logic             sclr;
    logic             clr_err;
    logic             wren;
    logic [WIDTH-1:0] datain;
    logic             rden;
    logic [WIDTH-1:0] dataout;
    logic             full;
    logic             empty;
    logic [PTR:0]     usedw;
    logic             almost_full;
    logic             almost_empty;
    logic             overflow;
    logic             underflow;

    modport master (
        output sclr, clr_err, wren, datain, rden,
        input  dataout, full, empty, usedw, almost_full, almost_empty,
               overflow, underflow
    );

    modport slave (
        input  sclr, clr_err, wren, datain, rden,
        output dataout, full, empty, usedw, almost_full, almost_empty,
               overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock power-of-two FIFO with normal or show-ahead read, programmable
// almost-full/almost-empty thresholds, synchronous clear and sticky error flags.
module sync_fifo_flags #(
    parameter int WIDTH     = 8,
    parameter int PTR       = 4,
    parameter int DEPTH     = 16,
    parameter int SHOWAHEAD = 0,
    parameter int AF_LEVEL  = 12,
    parameter int AE_LEVEL  = 2
) (
    input  logic              clk,
    input  logic              reset_,
    sync_fifo_flags_if.slave  bus
);
    localparam logic [PTR:0] L_DEPTH = (PTR+1)'(DEPTH);
    localparam logic [PTR:0] L_AF    = (PTR+1)'(AF_LEVEL);
    localparam logic [PTR:0] L_AE    = (PTR+1)'(AE_LEVEL);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR-1:0]   r_wr_ptr;
    logic [PTR-1:0]   r_rd_ptr;
    logic [PTR:0]     r_usedw;
    logic             r_overflow;
    logic             r_underflow;

    logic w_full;
    logic w_empty;
    logic w_wr_acc;
    logic w_rd_acc;

    // Status decodes only from the registered count, never from the requests.
    assign w_full   = (r_usedw == L_DEPTH);
    assign w_empty  = (r_usedw == '0);
    assign w_wr_acc = bus.wren & ~w_full  & ~bus.sclr;
    assign w_rd_acc = bus.rden & ~w_empty & ~bus.sclr;

    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.datain;
        end
    end

    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
        end else if (bus.sclr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_usedw  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + PTR'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_usedw <= r_usedw + (PTR+1)'(1);
                2'b01:   r_usedw <= r_usedw - (PTR+1)'(1);
                default: r_usedw <= r_usedw;
            endcase
        end
    end

    // A rejected request in the same cycle as a clear keeps its flag set.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (bus.wren & w_full) begin
                r_overflow <= 1'b1;
            end else if (bus.clr_err | bus.sclr) begin
                r_overflow <= 1'b0;
            end
            if (bus.rden & w_empty) begin
                r_underflow <= 1'b1;
            end else if (bus.clr_err | bus.sclr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    generate
        if (SHOWAHEAD != 0) begin : g_showahead
            assign bus.dataout = w_empty ? '0 : r_mem[r_rd_ptr];
        end else begin : g_normal
            logic [WIDTH-1:0] r_dataout;
            always_ff @(posedge clk or negedge reset_) begin
                if (!reset_) begin
                    r_dataout <= '0;
                end else if (bus.sclr) begin
                    r_dataout <= '0;
                end else if (w_rd_acc) begin
                    r_dataout <= r_mem[r_rd_ptr];
                end
            end
            assign bus.dataout = r_dataout;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.usedw        = r_usedw;
    assign bus.almost_full  = (r_usedw >= L_AF);
    assign bus.almost_empty = (r_usedw <= L_AE);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: doc/sync_fifo_flags.md
# sync_fifo_flags

Single-clock, parametrised FIFO for the MAC datapath. It succeeds the dual-clock FIFO for blocks whose producer and consumer share one clock. Compared with that FIFO it adds:
- power-of-two depth with natural pointer wrap
- a compile-time normal / show-ahead read mode
- programmable almost-full and almost-empty thresholds
- synchronous clear
- sticky overflow and underflow error flags

## Interface
Parameters:
- WIDTH, 8, data width in bits
- PTR, 4, pointer width; DEPTH must equal 2**PTR
- DEPTH, 16, number of entries
- SHOWAHEAD, 0, 0 = normal registered read, 1 = show-ahead (first-word-fall-through)
- AF_LEVEL, 12, almost_full asserts when usedw >= AF_LEVEL
- AE_LEVEL, 2, almost_empty asserts when usedw <= AE_LEVEL; 1 <= AE_LEVEL < AF_LEVEL <= DEPTH

Ports:
- clk  in  1  single clock for all logic
- reset_  in  1  one clock; reset is asynchronous and active-low
- sclr  in  1  synchronous clear of pointers, count, dataout and error flags
- wren  in  1  write request
- datain  in  WIDTH  write data
- rden  in  1  read request (acknowledge in show-ahead mode)
- dataout  out  WIDTH  read data
- full  out  1  usedw == DEPTH
- empty  out  1  usedw == 0
- usedw  out  PTR+1  occupied entries, 0..DEPTH
- almost_full  out  1  usedw >= AF_LEVEL
- almost_empty  out  1  usedw <= AE_LEVEL
- overflow  out  1  sticky; a write was rejected because the FIFO was full
- underflow  out  1  sticky; a read was rejected because the FIFO was empty
- clr_err  in  1  synchronous clear of overflow and underflow

## Operation
- Write accepted when wren & !full: mem[wr_ptr] <= datain; wr_ptr increments.
- Read accepted when rden & !empty: rd_ptr increments.
- Pointers are PTR bits wide and wrap DEPTH-1 -> 0 with no special case.
- usedw is a registered PTR+1-bit counter:
  - +1 on accepted write only
  - -1 on accepted read only
  - unchanged when both or neither are accepted
- full, empty, almost_full and almost_empty decode combinationally from the registered usedw only, never from wren/rden.
- Simultaneous write and read:
  - Not full and not empty: both are accepted; usedw is unchanged.
  - Full: the read is accepted and the write is rejected; overflow sets.
  - Empty: the write is accepted and the read is rejected; underflow sets.
- Normal mode (SHOWAHEAD=0): on an accepted read, dataout <= mem[rd_ptr]. Otherwise dataout holds.
- Show-ahead mode (SHOWAHEAD=1): dataout = mem[rd_ptr] combinationally while !empty, and is 0 while empty. An accepted read advances to the next word.
- Error flags:
  - overflow sets on wren & full; underflow sets on rden & empty.
  - Both clear on clr_err or sclr.
  - A set condition in the same cycle as a clear wins: the flag stays 1.
- sclr takes precedence over wren/rden in the same cycle:
  - Pointers, usedw and dataout go to 0; error flags clear.
  - Memory contents are not cleared; the write in that cycle is dropped.
- Memory has no reset.

## Timing
- Reset values, applied immediately on reset_ low without a clock edge:
  - dataout 0, usedw 0, full 0, empty 1
  - almost_full 0, almost_empty 1, overflow 0, underflow 0
- Reset is released synchronously by the integrator; the block needs no internal synchroniser.
- Write at edge N: usedw, empty and the almost flags update after edge N.
- Normal mode: the earliest read is at edge N+1, with data on dataout after edge N+1. Write-to-data latency is 2 edges.
- Show-ahead mode: data is visible on dataout after edge N (1 edge).
- Reset mid-operation discards all contents; the first post-reset write lands at entry 0.
- Back-to-back read and write every cycle sustains one word per clock with usedw constant.

## Test plan
- Fill/drain, DEPTH=16, normal mode:
  - Write 0x00..0x0F: full=1 after the 16th edge; almost_full rises at usedw=12.
  - Read 16: dataout = 0x00..0x0F in order, each one edge after its read; empty=1 at the end; almost_empty=1 from usedw=2.
- Wrap-around: run 40 writes interleaved with reads, holding occupancy at 5. Data order is preserved across 2+ pointer wraps; usedw stays 5.
- Boundary simultaneity:
  - Full plus wren&rden: usedw goes 16 -> 15 and overflow=1.
  - Empty plus wren&rden: usedw goes 0 -> 1, underflow=1, dataout unchanged.
- Show-ahead, SHOWAHEAD=1:
  - Write 0xA5 into an empty FIFO: dataout=0xA5 after the same edge, with no rden.
  - rden -> empty=1 and dataout=0.
- Error/clear:
  - Set overflow, then assert clr_err and wren&full in the same cycle: overflow stays 1. Next clr_err alone -> 0.
  - sclr with usedw=7: usedw=0, empty=1, flags 0 next cycle.
- Async reset mid-stream: drop reset_ between clock edges with usedw=9. Outputs take their reset values immediately. After release, write 0x3C then read: 0x3C returned.
